// File: rtl/mm_pkg.sv
// Shared definitions for the 4x4 signed matrix-multiply engine and its result collector.
package mm_pkg;

   localparam int MM_DATA_W  = 20;
   localparam int MM_MAX_DIM = 4;
   localparam int IDX_W      = 2;
   localparam int CNT_W      = 3;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      DRAIN   = 2'd2
   } mm_state_e;

   // Limit a dimension count to the buffer size (overflowed rows/columns were never stored)
   function automatic logic [CNT_W-1:0] clamp_dim(input logic [CNT_W-1:0] n,
                                                  input logic [CNT_W-1:0] lim);
      return (n > lim) ? lim : n;
   endfunction

endpackage

// File: rtl/mm_result_buf.sv
// MAX_DIM x MAX_DIM result register file: one synchronous write port, one combinational read port.
module mm_result_buf
   import mm_pkg::*;
#(
   parameter int DATA_W  = MM_DATA_W,
   parameter int MAX_DIM = MM_MAX_DIM
) (
   input  logic              clk,
   input  logic              we,
   input  logic [IDX_W-1:0]  wrow,
   input  logic [IDX_W-1:0]  wcol,
   input  logic [DATA_W-1:0] wdata,
   input  logic [IDX_W-1:0]  rrow,
   input  logic [IDX_W-1:0]  rcol,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem_r [MAX_DIM][MAX_DIM];

   // Element store; contents are meaningless until written in the current frame
   always_ff @(posedge clk) begin
      if (we) begin
         mem_r[wrow][wcol] <= wdata;
      end
   end

   assign rdata = mem_r[rrow][rcol];

endmodule

// File: rtl/mm_result_collector.sv
// Captures the engine's serial result stream into a local buffer, infers the result
// dimensions, and replays the frame row-major over a ready/valid port.
module mm_result_collector
   import mm_pkg::*;
#(
   parameter int DATA_W  = MM_DATA_W,
   parameter int MAX_DIM = MM_MAX_DIM
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] mm_out_data,
   input  logic              mm_valid,
   input  logic              mm_is_legal,
   input  logic              mm_change_row,
   input  logic              mm_busy,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [DATA_W-1:0] res_data,
   output logic [IDX_W-1:0]  res_row,
   output logic [IDX_W-1:0]  res_col,
   output logic              res_last,
   output logic              res_illegal,
   output logic              collect_busy,
   output logic              err
);

   localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_DIM);
   localparam logic [CNT_W-1:0] ONE_C = 3'd1;

   mm_state_e         state_r;
   logic              busy_prev_r, ill_r, stored_r, err_r;
   logic [CNT_W-1:0]  row_r, col_r, n_rows_r, n_cols_r;
   logic              res_valid_r, res_last_r, res_illegal_r, collect_busy_r;
   logic [DATA_W-1:0] res_data_r;
   logic [IDX_W-1:0]  res_row_r, res_col_r;

   logic              fall_s, we_s, nxt_last_s, fin_last_s;
   logic [CNT_W-1:0]  row_cnt_s, col_inc_s, nxt_row_s, nxt_col_s, fin_rows_s, fin_cols_s;
   logic [IDX_W-1:0]  rrow_s, rcol_s;
   logic [DATA_W-1:0] rdata_s;

   // Write qualification, next replay index and frame-end dimensions
   always_comb begin
      fall_s    = busy_prev_r & ~mm_busy;
      row_cnt_s = col_r + ONE_C;
      if ((state_r == COLLECT) && !fall_s && mm_valid && mm_is_legal &&
          (row_r < MAX_C) && (col_r < MAX_C)) begin
         we_s = 1'b1;
      end else begin
         we_s = 1'b0;
      end
      col_inc_s = CNT_W'(res_col_r) + ONE_C;
      if (col_inc_s == n_cols_r) begin
         nxt_row_s = CNT_W'(res_row_r) + ONE_C;
         nxt_col_s = 3'd0;
      end else begin
         nxt_row_s = CNT_W'(res_row_r);
         nxt_col_s = col_inc_s;
      end
      nxt_last_s = (nxt_row_s == (n_rows_r - ONE_C)) && (nxt_col_s == (n_cols_r - ONE_C));
      // The read port looks one beat ahead while draining, at (0,0) otherwise
      if (state_r == DRAIN) begin
         rrow_s = nxt_row_s[IDX_W-1:0];
         rcol_s = nxt_col_s[IDX_W-1:0];
      end else begin
         rrow_s = {IDX_W{1'b0}};
         rcol_s = {IDX_W{1'b0}};
      end
      fin_cols_s = clamp_dim((n_cols_r != 3'd0) ? n_cols_r : col_r, MAX_C);
      fin_rows_s = clamp_dim(row_r + {{(CNT_W-1){1'b0}}, (col_r != 3'd0)}, MAX_C);
      fin_last_s = (fin_rows_s == ONE_C) && (fin_cols_s == ONE_C);
   end

   mm_result_buf #(.DATA_W(DATA_W), .MAX_DIM(MAX_DIM)) u_buf (
      .clk   (clk),
      .we    (we_s),
      .wrow  (row_r[IDX_W-1:0]),
      .wcol  (col_r[IDX_W-1:0]),
      .wdata (mm_out_data),
      .rrow  (rrow_s),
      .rcol  (rcol_s),
      .rdata (rdata_s)
   );

   // Collector FSM, dimension counters, sticky error and registered result port
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r        <= IDLE;
         busy_prev_r    <= 1'b0;
         ill_r          <= 1'b0;
         stored_r       <= 1'b0;
         err_r          <= 1'b0;
         row_r          <= 3'd0;
         col_r          <= 3'd0;
         n_rows_r       <= 3'd0;
         n_cols_r       <= 3'd0;
         res_valid_r    <= 1'b0;
         res_data_r     <= '0;
         res_row_r      <= 2'd0;
         res_col_r      <= 2'd0;
         res_last_r     <= 1'b0;
         res_illegal_r  <= 1'b0;
         collect_busy_r <= 1'b0;
      end else begin
         busy_prev_r <= mm_busy;
         case (state_r)
            IDLE: begin
               if (mm_busy) begin
                  state_r <= COLLECT;
               end
            end
            COLLECT: begin
               if (fall_s) begin
                  if (ill_r) begin
                     state_r        <= DRAIN;
                     collect_busy_r <= 1'b1;
                     res_valid_r    <= 1'b1;
                     res_data_r     <= '0;
                     res_row_r      <= 2'd0;
                     res_col_r      <= 2'd0;
                     res_last_r     <= 1'b1;
                     res_illegal_r  <= 1'b1;
                  end else if (stored_r) begin
                     state_r        <= DRAIN;
                     collect_busy_r <= 1'b1;
                     res_valid_r    <= 1'b1;
                     res_data_r     <= rdata_s;
                     res_row_r      <= 2'd0;
                     res_col_r      <= 2'd0;
                     res_last_r     <= fin_last_s;
                     res_illegal_r  <= 1'b0;
                     n_rows_r       <= fin_rows_s;
                     n_cols_r       <= fin_cols_s;
                  end else begin
                     state_r  <= IDLE;
                     row_r    <= 3'd0;
                     col_r    <= 3'd0;
                     n_cols_r <= 3'd0;
                  end
               end else if (mm_valid) begin
                  if (!mm_is_legal) begin
                     ill_r <= 1'b1;
                  end else begin
                     if (we_s) begin
                        col_r    <= col_r + ONE_C;
                        stored_r <= 1'b1;
                     end else begin
                        err_r <= 1'b1;
                     end
                     if (mm_change_row) begin
                        col_r <= 3'd0;
                        if (row_r < MAX_C) begin
                           row_r <= row_r + ONE_C;
                        end
                        if (row_r == 3'd0) begin
                           n_cols_r <= row_cnt_s;
                        end else if (row_cnt_s != n_cols_r) begin
                           err_r <= 1'b1;
                        end
                     end
                  end
               end
            end
            DRAIN: begin
               if (mm_valid) begin
                  err_r <= 1'b1;
               end
               if (res_valid_r && res_ready) begin
                  if (res_last_r) begin
                     state_r        <= IDLE;
                     collect_busy_r <= 1'b0;
                     res_valid_r    <= 1'b0;
                     res_data_r     <= '0;
                     res_row_r      <= 2'd0;
                     res_col_r      <= 2'd0;
                     res_last_r     <= 1'b0;
                     res_illegal_r  <= 1'b0;
                     ill_r          <= 1'b0;
                     stored_r       <= 1'b0;
                     row_r          <= 3'd0;
                     col_r          <= 3'd0;
                     n_rows_r       <= 3'd0;
                     n_cols_r       <= 3'd0;
                  end else begin
                     res_row_r  <= nxt_row_s[IDX_W-1:0];
                     res_col_r  <= nxt_col_s[IDX_W-1:0];
                     res_data_r <= rdata_s;
                     res_last_r <= nxt_last_s;
                  end
               end
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign res_valid    = res_valid_r;
   assign res_data     = res_data_r;
   assign res_row      = res_row_r;
   assign res_col      = res_col_r;
   assign res_last     = res_last_r;
   assign res_illegal  = res_illegal_r;
   assign collect_busy = collect_busy_r;
   assign err          = err_r;

endmodule

// File: tb/tb_mm_result_collector.sv
// Directed bench for mm_result_collector: table of stream elements with their expected replay beats.
module tb_mm_result_collector;

   localparam int DW = 20;

   typedef struct {
      int            frame;
      logic [DW-1:0] din;
      logic          cr;
      logic [1:0]    erow;
      logic [1:0]    ecol;
      logic          elast;
   } vec_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [DW-1:0] mm_out_data = '0;
   logic          mm_valid = 1'b0, mm_is_legal = 1'b0, mm_change_row = 1'b0, mm_busy = 1'b0;
   logic          res_ready = 1'b0;
   logic          res_valid, res_last, res_illegal, collect_busy, err;
   logic [DW-1:0] res_data;
   logic [1:0]    res_row, res_col;

   int            n_cmp = 0;
   int            n_bad = 0;
   vec_t          tbl[$];
   logic [25:0]   exp_q[$];
   int            cb;

   mm_result_collector dut (
      .clk(clk), .rst_n(rst_n), .mm_out_data(mm_out_data), .mm_valid(mm_valid),
      .mm_is_legal(mm_is_legal), .mm_change_row(mm_change_row), .mm_busy(mm_busy),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_row(res_row),
      .res_col(res_col), .res_last(res_last), .res_illegal(res_illegal),
      .collect_busy(collect_busy), .err(err)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(int f, int d, logic cr, int r, int c, logic l);
      vec_t v;
      v.frame = f; v.din = DW'(d); v.cr = cr; v.erow = 2'(r); v.ecol = 2'(c); v.elast = l;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [25:0] beat();
      return {res_data, res_row, res_col, res_last, res_illegal};
   endfunction

   function automatic logic [31:0] all_out();
      return {3'd0, res_valid, res_data, res_row, res_col, res_last, res_illegal, collect_busy, err};
   endfunction

   task automatic send_frame(input int f);
      mm_busy = 1'b1;
      @(posedge clk); #1;
      foreach (tbl[i]) begin
         if (tbl[i].frame == f) begin
            mm_valid = 1'b1; mm_is_legal = 1'b1;
            mm_out_data = tbl[i].din; mm_change_row = tbl[i].cr;
            exp_q.push_back({tbl[i].din, tbl[i].erow, tbl[i].ecol, tbl[i].elast, 1'b0});
            @(posedge clk); #1;
         end
      end
      mm_valid = 1'b0; mm_change_row = 1'b0; mm_busy = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic drain(input bit toggle, input string tag, output int cb_cnt);
      int          k = 0;
      int          cyc = 0;
      int          n = exp_q.size();
      logic        held = 1'b0;
      logic [25:0] saved = '0;
      cb_cnt = 0;
      check({tag, "_latency"}, 32'(res_valid), 32'd1);
      while (k < n && cyc < 200) begin
         res_ready = toggle ? ((cyc % 2) == 0) : 1'b1;
         if (collect_busy) cb_cnt++;
         if (res_valid) begin
            if (held) check({tag, "_stall_hold"}, 32'(beat()), 32'(saved));
            if (res_ready) begin
               check({tag, "_beat"}, 32'(beat()), 32'(exp_q[k]));
               k++;
               held = 1'b0;
            end else begin
               held = 1'b1;
               saved = beat();
            end
         end
         @(posedge clk); #1;
         cyc++;
      end
      res_ready = 1'b0;
      if (k < n) check({tag, "_timeout_beats"}, 32'(k), 32'(n));
      check({tag, "_post_busy_valid"}, {30'd0, collect_busy, res_valid}, 32'd0);
      exp_q.delete();
   endtask

   task automatic flush(input string tag);
      logic done = 1'b0;
      exp_q.delete();
      for (int c = 0; c < 100 && !done; c++) begin
         res_ready = 1'b1;
         done = res_valid && res_last;
         @(posedge clk); #1;
      end
      res_ready = 1'b0;
      if (!done) check({tag, "_flush_timeout"}, 32'd0, 32'd1);
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      #1;
      check("reset_clears_all", all_out(), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   initial begin
      // frame 0: 2x2 result of 2x3 * 3x2
      tbl.push_back(mk(0, 1, 1'b0, 0, 0, 1'b0)); tbl.push_back(mk(0, 2, 1'b1, 0, 1, 1'b0));
      tbl.push_back(mk(0, 3, 1'b0, 1, 0, 1'b0)); tbl.push_back(mk(0, 4, 1'b1, 1, 1, 1'b1));
      // frame 1: 1x1
      tbl.push_back(mk(1, -7, 1'b1, 0, 0, 1'b1));
      // frame 2: 3x3
      tbl.push_back(mk(2, 10, 1'b0, 0, 0, 1'b0)); tbl.push_back(mk(2, -11, 1'b0, 0, 1, 1'b0));
      tbl.push_back(mk(2, 12, 1'b1, 0, 2, 1'b0)); tbl.push_back(mk(2, -13, 1'b0, 1, 0, 1'b0));
      tbl.push_back(mk(2, 14, 1'b0, 1, 1, 1'b0)); tbl.push_back(mk(2, -15, 1'b1, 1, 2, 1'b0));
      tbl.push_back(mk(2, 16, 1'b0, 2, 0, 1'b0)); tbl.push_back(mk(2, -17, 1'b0, 2, 1, 1'b0));
      tbl.push_back(mk(2, 18, 1'b1, 2, 2, 1'b1));
      // frame 3: 4x4 with extreme values
      tbl.push_back(mk(3, -524288, 1'b0, 0, 0, 1'b0)); tbl.push_back(mk(3, 524287, 1'b0, 0, 1, 1'b0));
      tbl.push_back(mk(3, 0, 1'b0, 0, 2, 1'b0));       tbl.push_back(mk(3, -1, 1'b1, 0, 3, 1'b0));
      tbl.push_back(mk(3, 524287, 1'b0, 1, 0, 1'b0));  tbl.push_back(mk(3, -524288, 1'b0, 1, 1, 1'b0));
      tbl.push_back(mk(3, 1, 1'b0, 1, 2, 1'b0));       tbl.push_back(mk(3, -2, 1'b1, 1, 3, 1'b0));
      tbl.push_back(mk(3, 12345, 1'b0, 2, 0, 1'b0));   tbl.push_back(mk(3, -12345, 1'b0, 2, 1, 1'b0));
      tbl.push_back(mk(3, 524287, 1'b0, 2, 2, 1'b0));  tbl.push_back(mk(3, -524288, 1'b1, 2, 3, 1'b0));
      tbl.push_back(mk(3, -1, 1'b0, 3, 0, 1'b0));      tbl.push_back(mk(3, 1, 1'b0, 3, 1, 1'b0));
      tbl.push_back(mk(3, -524288, 1'b0, 3, 2, 1'b0)); tbl.push_back(mk(3, 524287, 1'b1, 3, 3, 1'b1));
      // frame 4: ragged rows (3 then 2); frame 5: five columns
      tbl.push_back(mk(4, 1, 1'b0, 0, 0, 1'b0)); tbl.push_back(mk(4, 2, 1'b0, 0, 0, 1'b0));
      tbl.push_back(mk(4, 3, 1'b1, 0, 0, 1'b0)); tbl.push_back(mk(4, 4, 1'b0, 0, 0, 1'b0));
      tbl.push_back(mk(4, 5, 1'b1, 0, 0, 1'b0));
      for (int i = 1; i <= 5; i++) tbl.push_back(mk(5, i, (i == 5), 0, 0, 1'b0));

      #12;
      check("reset_values", all_out(), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      send_frame(0);
      drain(1'b0, "f2x2", cb);
      check("f2x2_collect_busy_cycles", 32'(cb), 32'd4);
      check("f2x2_err", 32'(err), 32'd0);

      // illegal-dimension frame
      mm_busy = 1'b1;
      @(posedge clk); #1;
      mm_valid = 1'b1; mm_is_legal = 1'b0; mm_out_data = 20'h12345;
      @(posedge clk); #1;
      mm_valid = 1'b0; mm_busy = 1'b0;
      @(posedge clk); #1;
      exp_q.push_back({20'h0, 2'd0, 2'd0, 1'b1, 1'b1});
      drain(1'b0, "illegal", cb);
      check("illegal_err", 32'(err), 32'd0);

      send_frame(1);
      drain(1'b0, "f1x1", cb);
      send_frame(2);
      drain(1'b0, "f3x3", cb);
      check("b2b_err", 32'(err), 32'd0);

      send_frame(3);
      drain(1'b1, "f4x4_stall", cb);
      check("f4x4_err", 32'(err), 32'd0);

      send_frame(4);
      flush("ragged");
      check("ragged_err_set", 32'(err), 32'd1);
      repeat (3) @(posedge clk);
      #1;
      check("ragged_err_sticky", 32'(err), 32'd1);
      pulse_reset();

      send_frame(5);
      flush("col5");
      check("col5_err_set", 32'(err), 32'd1);
      pulse_reset();

      // reset in the middle of a 4x4 drain, then a clean frame
      send_frame(3);
      exp_q.delete();
      res_ready = 1'b1;
      repeat (5) @(posedge clk);
      #4;
      res_ready = 1'b0;
      pulse_reset();
      send_frame(0);
      drain(1'b0, "after_reset", cb);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
